// File: rtl/bcd_div11_range_scanner_if.sv
// Scan request/result bundle for the BCD divisible-by-11 range scanner.
// master = requester (start, range, hold, abort); slave = scanner (status and hit stream).
interface bcd_div11_range_scanner_if #(
   parameter int COUNT_W = 10
);
   logic               start;
   logic [15:0]        start_val;
   logic [15:0]        end_val;
   logic               hold;
   logic               abort;
   logic               busy;
   logic               done;
   logic               err;
   logic               hit_valid;
   logic [15:0]        hit_val;
   logic [COUNT_W-1:0] hit_count;

   modport master (
      output start, start_val, end_val, hold, abort,
      input  busy, done, err, hit_valid, hit_val, hit_count
   );

   modport slave (
      input  start, start_val, end_val, hold, abort,
      output busy, done, err, hit_valid, hit_val, hit_count
   );
endinterface

// File: rtl/bcd_div11_range_scanner.sv
// Sweeps a packed-BCD range one value per clock and streams multiples of 11; done at start+N+2.
// hold freezes the sweep without losing values; abort ends early with the partial count kept.
module bcd_div11_range_scanner #(
   parameter int COUNT_W = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   bcd_div11_range_scanner_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

   state_t             state;
   logic [15:0]        cur_val;
   logic [15:0]        end_reg;
   logic               busy_r;
   logic               done_r;
   logic               err_r;
   logic               hit_valid_r;
   logic [15:0]        hit_val_r;
   logic [COUNT_W-1:0] hit_count_r;

   logic               cur_hit;
   logic               range_ok;
   logic [COUNT_W-1:0] count_inc;

   function automatic logic is_bcd(input logic [15:0] v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
             (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
   endfunction

   // Alternating digit sum lies in -18..+18, so only 0 and +/-11 mark a multiple.
   function automatic logic div11(input logic [15:0] v);
      logic signed [5:0] s;
      s = $signed({2'b00, v[3:0]}) + $signed({2'b00, v[11:8]})
        - $signed({2'b00, v[7:4]}) - $signed({2'b00, v[15:12]});
      return (s == 6'sd0) || (s == 6'sd11) || (s == -6'sd11);
   endfunction

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // For valid BCD the numeric order is the plain binary order of the packed word.
   assign cur_hit   = div11(cur_val);
   assign range_ok  = is_bcd(cur_val) && is_bcd(end_reg) && (cur_val <= end_reg);
   assign count_inc = (hit_count_r == {COUNT_W{1'b1}}) ? hit_count_r
                                                       : hit_count_r + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cur_val     <= '0;
         end_reg     <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         hit_valid_r <= 1'b0;
         hit_val_r   <= '0;
         hit_count_r <= '0;
      end else begin
         done_r      <= 1'b0;
         hit_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  cur_val     <= bus.start_val;
                  end_reg     <= bus.end_val;
                  hit_count_r <= '0;
                  err_r       <= 1'b0;
                  busy_r      <= 1'b1;
                  state       <= CHECK;
               end
            end
            CHECK: begin
               if (bus.abort) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end else if (!range_ok) begin
                  err_r  <= 1'b1;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end else begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               // abort overrides hold, and the value under test on that cycle still counts
               if (bus.abort || !bus.hold) begin
                  if (cur_hit) begin
                     hit_valid_r <= 1'b1;
                     hit_val_r   <= cur_val;
                     hit_count_r <= count_inc;
                  end
                  if (bus.abort || (cur_val == end_reg)) begin
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     state  <= DONE;
                  end else begin
                     cur_val <= bcd_inc(cur_val);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.hit_valid = hit_valid_r;
   assign bus.hit_val   = hit_val_r;
   assign bus.hit_count = hit_count_r;

endmodule

// File: tb/tb_bcd_div11_range_scanner.sv
// Scoreboard bench for the BCD divisible-by-11 range scanner: integer reference model,
// expectations queued at stimulus time, monitor compares hits and completion results.
module tb_bcd_div11_range_scanner;

   typedef struct {
      logic err;
      int   count;
      int   done_cyc;
      int   busy;
   } exp_done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   busy_cnt = 0;
   int   scan_hits = 0;

   logic [15:0] exp_hits[$];
   exp_done_t   exp_done[$];

   bcd_div11_range_scanner_if #(.COUNT_W(10)) bus ();

   bcd_div11_range_scanner #(.COUNT_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit bcd_ok(input logic [15:0] b);
      for (int j = 0; j < 4; j++)
         if (b[4*j +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int to_int(input logic [15:0] b);
      return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the scanner presents a hit or a completion.
   always @(negedge clk) begin
      logic [15:0] e;
      exp_done_t   d;
      if (!rst_n) begin
         busy_cnt  = 0;
         scan_hits = 0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.hit_valid) begin
            if (exp_hits.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_hit: got %0h, none expected", bus.hit_val);
            end else begin
               e = exp_hits.pop_front();
               chk("hit_val", bus.hit_val, e);
               scan_hits++;
               chk("hit_count_running", bus.hit_count, scan_hits);
            end
         end
         if (bus.done) begin
            if (exp_done.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d, none expected", cyc);
            end else begin
               d = exp_done.pop_front();
               chk("done_err", bus.err, d.err);
               chk("done_count", bus.hit_count, d.count);
               if (d.done_cyc >= 0) chk("done_cycle", cyc, d.done_cyc);
               if (d.busy >= 0) chk("busy_cycles", busy_cnt, d.busy);
               chk("hits_missing", exp_hits.size(), 0);
               exp_hits.delete();
            end
            busy_cnt  = 0;
            scan_hits = 0;
         end
      end
   end

   task automatic launch(input logic [15:0] sv, input logic [15:0] ev, input int hold_cycles,
                         input int max_hits, input bit timed);
      exp_done_t d;
      int k, n, hits;
      @(negedge clk);
      k    = cyc + 1;
      hits = 0;
      if (!bcd_ok(sv) || !bcd_ok(ev) || to_int(sv) > to_int(ev)) begin
         d.err = 1'b1; d.count = 0; d.done_cyc = k + 1; d.busy = 1;
      end else begin
         n = to_int(ev) - to_int(sv) + 1;
         for (int v = to_int(sv); v <= to_int(ev); v++)
            if (v % 11 == 0 && hits < max_hits) begin
               exp_hits.push_back(to_bcd(v));
               hits++;
            end
         d.err = 1'b0; d.count = hits; d.done_cyc = k + n + 1 + hold_cycles;
         d.busy = n + 1 + hold_cycles;
      end
      if (!timed) begin
         d.done_cyc = -1;
         d.busy     = -1;
      end
      exp_done.push_back(d);
      bus.start     = 1'b1;
      bus.start_val = sv;
      bus.end_val   = ev;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.start_val = 16'($urandom);
      bus.end_val   = 16'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while (exp_done.size() != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (exp_done.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL scan_timeout: %0d results pending after %0d cycles, required 0",
                  exp_done.size(), budget);
         exp_done.delete();
         exp_hits.delete();
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_err"}, bus.err, 0);
      chk({tag, "_hit_valid"}, bus.hit_valid, 0);
      chk({tag, "_hit_val"}, bus.hit_val, 0);
      chk({tag, "_hit_count"}, bus.hit_count, 0);
   endtask

   initial begin
      int s, e, j;
      bit seen;
      logic [15:0] sv;
      bus.start = 1'b0; bus.hold = 1'b0; bus.abort = 1'b0;
      bus.start_val = '0; bus.end_val = '0;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst_n = 1'b1;

      launch(16'h0000, 16'h0099, 0, 10000, 1'b1); wait_idle(200);
      launch(16'h9080, 16'h9130, 0, 10000, 1'b1); wait_idle(200);
      launch(16'h7777, 16'h7777, 0, 10000, 1'b1); wait_idle(50);
      launch(16'h2121, 16'h2122, 0, 10000, 1'b1); wait_idle(50);
      launch(16'h0000, 16'h9999, 0, 10000, 1'b1); wait_idle(10100);
      launch(16'h00A0, 16'h0100, 0, 10000, 1'b1); wait_idle(50);
      launch(16'h0000, 16'h5F00, 0, 10000, 1'b1); wait_idle(50);
      launch(16'h0100, 16'h0050, 0, 10000, 1'b1); wait_idle(50);

      // Hold mid-scan with a stray start request that must be ignored.
      launch(16'h0000, 16'h0099, 5, 10000, 1'b1);
      repeat (30) @(negedge clk);
      bus.hold = 1'b1; bus.start = 1'b1; bus.start_val = 16'h0500; bus.end_val = 16'h0600;
      repeat (5) @(negedge clk);
      bus.hold = 1'b0; bus.start = 1'b0;
      wait_idle(200);

      // Abort right after the 0044 hit.
      launch(16'h0000, 16'h0099, 0, 5, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(negedge clk);
         if (bus.hit_valid && bus.hit_val == 16'h0044) seen = 1'b1;
      end
      chk("abort_hit_0044_seen", seen, 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      wait_idle(50);

      // Reset mid-scan: outputs clear at once, no completion, then a clean rescan.
      launch(16'h0000, 16'h0099, 0, 10000, 1'b1);
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero_outputs("midscan_reset");
      exp_hits.delete();
      exp_done.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      launch(16'h0000, 16'h0099, 0, 10000, 1'b1); wait_idle(200);

      for (int r = 0; r < 6; r++) begin
         s = int'($urandom_range(0, 9700));
         e = s + int'($urandom_range(0, 250));
         launch(to_bcd(s), to_bcd(e), 0, 10000, 1'b1);
         wait_idle(300);
      end
      for (int r = 0; r < 3; r++) begin
         sv = to_bcd(int'($urandom_range(0, 9999)));
         j  = int'($urandom_range(0, 3));
         sv[4*j +: 4] = 4'($urandom_range(10, 15));
         if (r[0]) launch(sv, 16'h9999, 0, 10000, 1'b1);
         else      launch(16'h0000, sv, 0, 10000, 1'b1);
         wait_idle(50);
      end
      s = int'($urandom_range(1, 9999));
      launch(to_bcd(s), to_bcd(int'($urandom_range(0, s - 1))), 0, 10000, 1'b1);
      wait_idle(50);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
